// File: rtl/dkong3_obj_dma_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dkong3_obj_dma_pkg
// Description : Shared widths and FSM state type for the object-table DMA.
// Revision    : 1.0 - initial release
// ============================================================================
package dkong3_obj_dma_pkg;

  localparam int SRC_W = 16;
  localparam int DST_W = 10;
  localparam int LEN_W = 10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_READ    = 3'd2,
    ST_WRITE   = 3'd3,
    ST_NEXT    = 3'd4,
    ST_RELEASE = 3'd5
  } dma_state_t;

endpackage
`default_nettype wire

// File: rtl/dkong3_obj_dma.sv
`default_nettype none
// ============================================================================
// Module      : dkong3_obj_dma
// Description : Copies the CPU object table from work RAM into object RAM
//               6P/6R. Takes the CPU bus via BUSRQ/BUSAK, reads a run of
//               bytes and emits the object-RAM write stream.
//               Optional macro DKONG3_OBJ_DMA_RETRIG_EN: a trigger while busy
//               is held as one pending transfer started after the current one.
// Revision    : 1.0 - initial release
// ============================================================================
module dkong3_obj_dma
  import dkong3_obj_dma_pkg::*;
#(
  parameter int SRC_WAIT = 1
) (
  input  logic             I_CLK_24M,
  input  logic             I_RST,
  input  logic             I_CLK_EN,
  input  logic             I_TRIG,
  input  logic [SRC_W-1:0] I_SRC_BASE,
  input  logic [DST_W-1:0] I_DST_BASE,
  input  logic [LEN_W-1:0] I_LEN,
  output logic             O_BUSRQn,
  input  logic             I_BUSAKn,
  output logic [SRC_W-1:0] O_SRC_A,
  output logic             O_SRC_RDn,
  input  logic [7:0]       I_SRC_D,
  output logic [DST_W-1:0] O_OBJ_DMA_A,
  output logic [7:0]       O_OBJ_DMA_D,
  output logic             O_OBJ_DMA_CE,
  output logic             O_BUSY,
  output logic             O_DONE
);

  // Last wait-count value of a READ; the read strobe spans SRC_WAIT+1 steps.
  localparam logic [2:0] c_wait_last = 3'(SRC_WAIT);

  dma_state_t       r_state, w_state_nxt;
  logic [SRC_W-1:0] r_src,   w_src_nxt;
  logic [DST_W-1:0] r_dst,   w_dst_nxt;
  logic [LEN_W-1:0] r_rem,   w_rem_nxt;
  logic [2:0]       r_wait,  w_wait_nxt;
  logic [7:0]       r_data,  w_data_nxt;
  logic             r_busrqn, r_rdn, r_ce, r_busy, r_done, w_done_nxt;

`ifdef DKONG3_OBJ_DMA_RETRIG_EN
  logic             r_pend,     w_pend_nxt;
  logic [SRC_W-1:0] r_pend_src, w_pend_src_nxt;
  logic [DST_W-1:0] r_pend_dst, w_pend_dst_nxt;
  logic [LEN_W-1:0] r_pend_len, w_pend_len_nxt;
`endif

  // Next-state, counter and registered-output decode.
  always_comb begin
    w_state_nxt = r_state;
    w_src_nxt   = r_src;
    w_dst_nxt   = r_dst;
    w_rem_nxt   = r_rem;
    w_wait_nxt  = r_wait;
    w_data_nxt  = r_data;
    w_done_nxt  = 1'b0;
`ifdef DKONG3_OBJ_DMA_RETRIG_EN
    w_pend_nxt     = r_pend;
    w_pend_src_nxt = r_pend_src;
    w_pend_dst_nxt = r_pend_dst;
    w_pend_len_nxt = r_pend_len;
    // A later trigger while busy simply replaces the held parameters.
    if (I_TRIG && (r_state != ST_IDLE)) begin
      w_pend_nxt     = 1'b1;
      w_pend_src_nxt = I_SRC_BASE;
      w_pend_dst_nxt = I_DST_BASE;
      w_pend_len_nxt = I_LEN;
    end
`endif
    case (r_state)
      ST_IDLE: begin
        if (I_TRIG) begin
          w_src_nxt = I_SRC_BASE;
          w_dst_nxt = I_DST_BASE;
          w_rem_nxt = I_LEN;
          if (I_LEN != '0) w_state_nxt = ST_REQ;
          else             w_done_nxt  = 1'b1;
        end
      end
      ST_REQ: begin
        if (!I_BUSAKn) begin
          w_state_nxt = ST_READ;
          w_wait_nxt  = '0;
        end
      end
      ST_READ: begin
        if (r_wait == c_wait_last) begin
          w_data_nxt  = I_SRC_D;
          w_state_nxt = ST_WRITE;
        end else begin
          w_wait_nxt = r_wait + 3'd1;
        end
      end
      ST_WRITE: w_state_nxt = ST_NEXT;
      ST_NEXT: begin
        w_src_nxt  = r_src + 1'b1;
        w_dst_nxt  = r_dst + 1'b1;
        w_rem_nxt  = r_rem - 1'b1;
        w_wait_nxt = '0;
        w_state_nxt = (r_rem == LEN_W'(1)) ? ST_RELEASE : ST_READ;
      end
      ST_RELEASE: begin
        if (I_BUSAKn) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_IDLE;
`ifdef DKONG3_OBJ_DMA_RETRIG_EN
          // Pending request (including one arriving right now) is consumed here.
          if (w_pend_nxt) begin
            w_pend_nxt = 1'b0;
            if (w_pend_len_nxt != '0) begin
              w_src_nxt   = w_pend_src_nxt;
              w_dst_nxt   = w_pend_dst_nxt;
              w_rem_nxt   = w_pend_len_nxt;
              w_state_nxt = ST_REQ;
            end
          end
`endif
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, counters and registered outputs; advance only on enabled edges.
  always_ff @(posedge I_CLK_24M) begin
    if (I_RST) begin
      r_state  <= ST_IDLE;
      r_src    <= '0;
      r_dst    <= '0;
      r_rem    <= '0;
      r_wait   <= '0;
      r_data   <= '0;
      r_busrqn <= 1'b1;
      r_rdn    <= 1'b1;
      r_ce     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
`ifdef DKONG3_OBJ_DMA_RETRIG_EN
      r_pend     <= 1'b0;
      r_pend_src <= '0;
      r_pend_dst <= '0;
      r_pend_len <= '0;
`endif
    end else if (I_CLK_EN) begin
      r_state  <= w_state_nxt;
      r_src    <= w_src_nxt;
      r_dst    <= w_dst_nxt;
      r_rem    <= w_rem_nxt;
      r_wait   <= w_wait_nxt;
      r_data   <= w_data_nxt;
      r_busrqn <= !((w_state_nxt == ST_REQ) || (w_state_nxt == ST_READ) ||
                    (w_state_nxt == ST_WRITE) || (w_state_nxt == ST_NEXT));
      r_rdn    <= (w_state_nxt != ST_READ);
      r_ce     <= (w_state_nxt == ST_WRITE);
      r_busy   <= (w_state_nxt != ST_IDLE);
      r_done   <= w_done_nxt;
`ifdef DKONG3_OBJ_DMA_RETRIG_EN
      r_pend     <= w_pend_nxt;
      r_pend_src <= w_pend_src_nxt;
      r_pend_dst <= w_pend_dst_nxt;
      r_pend_len <= w_pend_len_nxt;
`endif
    end
  end

  assign O_BUSRQn     = r_busrqn;
  assign O_SRC_A      = r_src;
  assign O_SRC_RDn    = r_rdn;
  assign O_OBJ_DMA_A  = r_dst;
  assign O_OBJ_DMA_D  = r_data;
  assign O_OBJ_DMA_CE = r_ce;
  assign O_BUSY       = r_busy;
  assign O_DONE       = r_done;

endmodule
`default_nettype wire
